// File: rtl/lfsr_deinterleaver.sv
// Receive-side inverse of the 8-bit LFSR block interleaver: rebuilds the index
// map from the shared x^4+x+1 LFSR, then scatters each input bit to its original position.
module lfsr_deinterleaver #(
  parameter logic [3:0] SEED   = 4'b1010,
  parameter logic [3:0] THRESH = 4'd8,
  parameter int         NSTEPS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       map_ok,
  output logic       busy
);

  localparam int STEPW = (NSTEPS > 2) ? $clog2(NSTEPS) : 1;

  typedef enum logic [1:0] {
    BUILD = 2'd0,
    CHECK = 2'd1,
    READY = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        lfsr_q, lfsr_d;
  logic [STEPW-1:0]  step_q, step_d;
  logic [23:0]       idx_q, idx_d;
  logic [7:0]        dout_q, dout_d;
  logic              doutValid_q, doutValid_d;
  logic              mapOk_q, mapOk_d;
  logic [7:0][2:0]   srcSel_q, srcSel_d;
  logic [7:0]        srcCov_q, srcCov_d;

  logic [7:0][2:0]   tableSel;
  logic [7:0]        tableCov;
  logic [7:0]        permuted;

  // Inverse table: output position idx_k takes input bit k; ascending k lets a later slot win.
  always_comb begin
    tableSel = '0;
    tableCov = '0;
    for (int k = 0; k < 8; k++) begin
      tableSel[idx_q[3*k +: 3]] = 3'(k);
      tableCov[idx_q[3*k +: 3]] = 1'b1;
    end
  end

  always_comb begin
    permuted = '0;
    for (int p = 0; p < 8; p++) begin
      permuted[p] = srcCov_q[p] & din[srcSel_q[p]];
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    step_d      = step_q;
    idx_d       = idx_q;
    dout_d      = dout_q;
    doutValid_d = 1'b0;
    mapOk_d     = mapOk_q;
    srcSel_d    = srcSel_q;
    srcCov_d    = srcCov_q;

    unique case (state_q)
      BUILD: begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[1], lfsr_q[3:1]};
        if (lfsr_q <= THRESH) begin
          idx_d = {lfsr_q[2:0], idx_q[23:3]};
        end
        step_d = step_q + 1'b1;
        if (step_q == STEPW'(NSTEPS - 1)) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        srcSel_d = tableSel;
        srcCov_d = tableCov;
        // Eight slots cover all eight positions exactly when they are all distinct.
        mapOk_d  = &tableCov;
        state_d  = READY;
      end

      READY: begin
        if (din_valid) begin
          dout_d      = permuted;
          doutValid_d = 1'b1;
        end
        if (restart) begin
          state_d = BUILD;
          lfsr_d  = SEED;
          step_d  = '0;
          idx_d   = '0;
          mapOk_d = 1'b0;
        end
      end

      default: begin
        state_d = BUILD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BUILD;
      lfsr_q      <= SEED;
      step_q      <= '0;
      idx_q       <= '0;
      dout_q      <= '0;
      doutValid_q <= 1'b0;
      mapOk_q     <= 1'b0;
      srcSel_q    <= '0;
      srcCov_q    <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      step_q      <= step_d;
      idx_q       <= idx_d;
      dout_q      <= dout_d;
      doutValid_q <= doutValid_d;
      mapOk_q     <= mapOk_d;
      srcSel_q    <= srcSel_d;
      srcCov_q    <= srcCov_d;
    end
  end

  assign din_ready  = (state_q == READY);
  assign busy       = (state_q != READY);
  assign dout       = dout_q;
  assign dout_valid = doutValid_q;
  assign map_ok     = mapOk_q;

endmodule

// File: tb/tb_lfsr_deinterleaver.sv
// Scoreboard bench for lfsr_deinterleaver: default-map instance plus a
// non-permutation variant, both checked against a queue-based reference model.
module tb_lfsr_deinterleaver;

  localparam int NSTEPS = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       restart = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;

  logic       dinReady0, doutValid0, mapOk0, busy0;
  logic [7:0] dout0;
  logic       dinReady1, doutValid1, mapOk1, busy1;
  logic [7:0] dout1;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [7:0] hold0 = 8'h00;
  logic [7:0] hold1 = 8'h00;
  logic [7:0][2:0] map0, map1;
  bit ok0, ok1;

  always #5 clk = ~clk;

  lfsr_deinterleaver dut0 (
    .clk(clk), .rst(rst), .restart(restart), .din(din), .din_valid(din_valid),
    .din_ready(dinReady0), .dout(dout0), .dout_valid(doutValid0),
    .map_ok(mapOk0), .busy(busy0)
  );

  lfsr_deinterleaver #(.SEED(4'b0001), .THRESH(4'd5), .NSTEPS(NSTEPS)) dut1 (
    .clk(clk), .rst(rst), .restart(restart), .din(din), .din_valid(din_valid),
    .din_ready(dinReady1), .dout(dout1), .dout_valid(doutValid1),
    .map_ok(mapOk1), .busy(busy1)
  );

  // Reference map: walk the LFSR as an integer, keep accepted values, newest eight land in slots 0..7.
  function automatic logic [7:0][2:0] modelMap(input int seed, input int thresh);
    logic [7:0][2:0] m;
    int acc[$];
    int v, n, j;
    m = '0;
    v = seed;
    for (int s = 0; s < NSTEPS; s++) begin
      if (v <= thresh) acc.push_back(v % 8);
      v = ((((v >> 1) ^ v) & 1) << 3) | (v >> 1);
    end
    n = acc.size();
    for (int k = 0; k < 8; k++) begin
      j = n - 8 + k;
      if (j >= 0) m[k] = 3'(acc[j]);
    end
    return m;
  endfunction

  function automatic bit modelOk(input logic [7:0][2:0] m);
    bit ok = 1'b1;
    for (int a = 0; a < 8; a++)
      for (int b = a + 1; b < 8; b++)
        if (m[a] == m[b]) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [7:0] deint(input logic [7:0][2:0] m, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    for (int k = 0; k < 8; k++) r[m[k]] = b[k];
    return r;
  endfunction

  function automatic logic [7:0] interleave(input logic [7:0][2:0] m, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    for (int k = 0; k < 8; k++) r[k] = b[m[k]];
    return r;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs at the negedge; a transfer is scored when the DUT is ready.
  task automatic applyStimulus(input logic [7:0] d, input bit v, input bit rs, input logic [7:0] e0);
    exp_t e;
    din       = d;
    din_valid = v;
    restart   = rs;
    if (v && !rst && dinReady0) begin
      e.data = e0;
      e.due  = cyc + 1;
      q0.push_back(e);
    end
    if (v && !rst && dinReady1) begin
      e.data = deint(map1, d);
      e.due  = cyc + 1;
      q1.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic sendByte(input logic [7:0] d);
    applyStimulus(d, 1'b1, 1'b0, deint(map0, d));
  endtask

  task automatic buildCycles(input int n, input bit v);
    logic [7:0] r;
    for (int i = 0; i < n; i++) begin
      checkOutput("busy0 during build", int'(busy0), 1);
      checkOutput("din_ready0 during build", int'(dinReady0), 0);
      checkOutput("map_ok0 during build", int'(mapOk0), 0);
      checkOutput("busy1 during build", int'(busy1), 1);
      checkOutput("din_ready1 during build", int'(dinReady1), 0);
      r = 8'($urandom);
      applyStimulus(r, v, 1'b0, deint(map0, r));
    end
  endtask

  task automatic expectReady();
    checkOutput("din_ready0 after build", int'(dinReady0), 1);
    checkOutput("busy0 after build", int'(busy0), 0);
    checkOutput("map_ok0", int'(mapOk0), int'(ok0));
    checkOutput("din_ready1 after build", int'(dinReady1), 1);
    checkOutput("map_ok1", int'(mapOk1), int'(ok1));
  endtask

  task automatic doReset(input bit pendingTransfer, input bit validDuringBuild);
    din       = 8'($urandom);
    din_valid = pendingTransfer;
    restart   = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    buildCycles(NSTEPS + 1, validDuringBuild);
    expectReady();
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      hold0 = 8'h00;
      hold1 = 8'h00;
    end
  end

  // Monitor: pops the scoreboards whenever a DUT presents an output, independent of the driver.
  always @(negedge clk) begin
    exp_t e;
    if (doutValid0) begin
      if (q0.size() == 0) checkOutput("dut0 unexpected dout_valid", 1, 0);
      else begin
        e = q0.pop_front();
        checkOutput("dut0 dout", int'(dout0), int'(e.data));
        checkOutput("dut0 latency", cyc, e.due);
        hold0 = e.data;
      end
    end else begin
      if (q0.size() > 0 && q0[0].due <= cyc) begin
        checkOutput("dut0 missing dout_valid", 0, 1);
        void'(q0.pop_front());
      end
      checkOutput("dut0 dout hold", int'(dout0), int'(hold0));
    end
    if (doutValid1) begin
      if (q1.size() == 0) checkOutput("dut1 unexpected dout_valid", 1, 0);
      else begin
        e = q1.pop_front();
        checkOutput("dut1 dout", int'(dout1), int'(e.data));
        checkOutput("dut1 latency", cyc, e.due);
        hold1 = e.data;
      end
    end else begin
      if (q1.size() > 0 && q1[0].due <= cyc) begin
        checkOutput("dut1 missing dout_valid", 0, 1);
        void'(q1.pop_front());
      end
      checkOutput("dut1 dout hold", int'(dout1), int'(hold1));
    end
  end

  initial begin
    logic [7:0] r;
    map0 = modelMap(4'b1010, 8);
    map1 = modelMap(4'b0001, 5);
    ok0  = modelOk(map0);
    ok1  = modelOk(map1);
    $display("[TB] start: model map_ok default=%0d variant=%0d", ok0, ok1);

    doReset(1'b0, 1'b0);

    applyStimulus(8'h01, 1'b1, 1'b0, 8'h80);
    idle(1);
    applyStimulus(8'h02, 1'b1, 1'b0, 8'h08);
    idle(1);
    applyStimulus(8'h20, 1'b1, 1'b0, 8'h04);
    idle(2);

    applyStimulus(8'hFF, 1'b1, 1'b0, 8'hFF);
    applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
    sendByte(8'hA5);
    idle(2);

    for (int b = 0; b < 256; b++) begin
      applyStimulus(interleave(map0, 8'(b)), 1'b1, 1'b0, 8'(b));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);

    for (int i = 0; i < 60; i++) begin
      r = 8'($urandom);
      applyStimulus(r, ($urandom_range(0, 9) < 7), 1'b0, deint(map0, r));
    end

    doReset(1'b1, 1'b1);
    sendByte(8'($urandom));
    sendByte(8'($urandom));
    idle(2);

    r = 8'($urandom);
    applyStimulus(r, 1'b1, 1'b1, deint(map0, r));
    buildCycles(NSTEPS + 1, 1'b1);
    expectReady();
    for (int i = 0; i < 8; i++) sendByte(8'(1 << i));
    idle(2);

    r = 8'($urandom);
    applyStimulus(r, 1'b1, 1'b1, deint(map0, r));
    buildCycles(7, 1'b0);
    doReset(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) sendByte(8'($urandom));
    idle(3);

    checkOutput("dut0 scoreboard drained", q0.size(), 0);
    checkOutput("dut1 scoreboard drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
